// File: rtl/soi_obs_pkg.sv
// Shared types for the signal-of-interest observation stage.
package soi_obs_pkg;

  // Capture controller states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // State to enter after a qualified sample, given whether it was the last one.
  function automatic state_t after_sample(input logic last);
    return last ? ST_DONE : ST_CAPTURE;
  endfunction

endpackage

// File: rtl/soi_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only when a pop happens in the same cycle; a pop while empty is ignored.
module soi_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is only driven while valid so an empty FIFO reads as zero.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/soi_capture.sv
// Trigger-and-capture stage: waits for the SOI to match a trigger value, then
// records a bounded burst of timestamped samples into a FWFT FIFO.
module soi_capture
  import soi_obs_pkg::*;
#(
  parameter int SOI_W = 8,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SOI_W-1:0] soi_i,
  input  logic             arm_i,
  input  logic             mode_i,
  input  logic [SOI_W-1:0] trig_val_i,
  input  logic [LEN_W-1:0] cap_len_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [SOI_W-1:0] rd_data_o,
  output logic [TS_W-1:0]  rd_ts_o,
  output logic [1:0]       state_o,
  output logic             overflow_o,
  output logic [LEN_W-1:0] count_o
);
  typedef struct packed {
    logic [SOI_W-1:0] value;
    logic [TS_W-1:0]  ts;
  } sample_t;

  state_t           state;
  state_t           state_next;
  logic             mode;
  logic [SOI_W-1:0] trig_val;
  logic [SOI_W-1:0] prev_soi;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] remaining_next;
  logic [TS_W-1:0]  ts;
  logic             overflow;
  logic             overflow_next;
  logic             qual;
  logic             pop;
  logic             full;
  logic             empty;
  sample_t          wr_sample;
  sample_t          rd_sample;

  assign pop       = !empty && rd_ready_i;
  assign wr_sample = '{value: soi_i, ts: ts};

  // Qualifier, countdown and next-state decode; an arm overrides any sampling.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    overflow_next  = overflow;
    qual           = 1'b0;
    if (arm_i) begin
      remaining_next = cap_len_i;
      overflow_next  = 1'b0;
      state_next     = (cap_len_i == '0) ? ST_DONE : ST_ARMED;
    end else begin
      case (state)
        ST_ARMED:   qual = (soi_i == trig_val);
        ST_CAPTURE: qual = mode ? (soi_i != prev_soi) : 1'b1;
        default:    qual = 1'b0;
      endcase
      if (qual) begin
        remaining_next = remaining - LEN_W'(1);
        state_next     = after_sample(remaining == LEN_W'(1));
        overflow_next  = overflow | (full & ~pop);
      end else begin
        remaining_next = remaining;
        state_next     = state;
        overflow_next  = overflow;
      end
    end
  end

  // Capture control registers: state, settings latched at arm, countdown, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode      <= 1'b0;
      trig_val  <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      overflow  <= overflow_next;
      if (arm_i) begin
        mode     <= mode_i;
        trig_val <= trig_val_i;
      end
    end
  end

  // Free-running timestamp and one-cycle SOI history, kept in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      prev_soi <= '0;
    end else begin
      ts       <= ts + TS_W'(1);
      prev_soi <= soi_i;
    end
  end

  soi_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (DEPTH),
    .CNT_W (LEN_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (qual),
    .wdata (wr_sample),
    .pop   (pop),
    .rdata (rd_sample),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  assign rd_valid_o = !empty;
  assign rd_data_o  = rd_sample.value;
  assign rd_ts_o    = rd_sample.ts;
  assign state_o    = state;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_soi_capture.sv
// Self-checking bench for soi_capture with a queue-based reference model.
module tb_soi_capture;
  localparam int SOI_W = 8;
  localparam int DEPTH = 4;
  localparam int TS_W  = 16;
  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SOI_W-1:0] soi_i = '0;
  logic             arm_i = 1'b0;
  logic             mode_i = 1'b0;
  logic [SOI_W-1:0] trig_val_i = '0;
  logic [LEN_W-1:0] cap_len_i = '0;
  logic             rd_ready_i = 1'b0;
  logic             rd_valid_o;
  logic [SOI_W-1:0] rd_data_o;
  logic [TS_W-1:0]  rd_ts_o;
  logic [1:0]       state_o;
  logic             overflow_o;
  logic [LEN_W-1:0] count_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  soi_capture #(.SOI_W(SOI_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .soi_i(soi_i), .arm_i(arm_i), .mode_i(mode_i),
    .trig_val_i(trig_val_i), .cap_len_i(cap_len_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ts_o(rd_ts_o),
    .state_o(state_o), .overflow_o(overflow_o), .count_o(count_o)
  );

  // Reference model: cycles since reset, capture phase, stored samples.
  logic [15:0] m_ts;
  logic [1:0]  m_state;
  int          m_rem;
  logic        m_mode;
  logic [7:0]  m_trig;
  logic [7:0]  m_prev;
  logic        m_ovf;
  logic [7:0]  q_val[$];
  logic [15:0] q_ts[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ts <= 16'd0;
    else        m_ts <= m_ts + 16'd1;
  end

  task automatic model_reset();
    m_state = 2'd0; m_rem = 0; m_mode = 1'b0; m_trig = 8'd0; m_prev = 8'd0; m_ovf = 1'b0;
    q_val.delete(); q_ts.delete();
  endtask

  function automatic logic [30:0] model_vec();
    logic [7:0]  hv;
    logic [15:0] ht;
    hv = (q_val.size() > 0) ? q_val[0] : 8'd0;
    ht = (q_ts.size() > 0) ? q_ts[0] : 16'd0;
    return {m_state, 3'(q_val.size()), (q_val.size() > 0), m_ovf, hv, ht};
  endfunction

  function automatic logic [30:0] dut_vec();
    return {state_o, count_o, rd_valid_o, overflow_o, rd_data_o, rd_ts_o};
  endfunction

  // Drive one cycle at the negedge, advance the model, land on the next negedge.
  task automatic step(input logic [7:0] soi, input logic arm, input logic mode,
                      input logic [7:0] trig, input logic [2:0] len, input logic rdy);
    int   pre;
    logic popd;
    logic qual;
    soi_i = soi; arm_i = arm; mode_i = mode; trig_val_i = trig; cap_len_i = len; rd_ready_i = rdy;
    pre  = q_val.size();
    popd = rdy && (pre > 0);
    qual = 1'b0;
    if (arm) begin
      m_mode = mode; m_trig = trig; m_rem = int'(len); m_ovf = 1'b0;
      m_state = (len == 3'd0) ? 2'd3 : 2'd1;
    end else if (m_state == 2'd1) qual = (soi == m_trig);
    else if (m_state == 2'd2) qual = m_mode ? (soi != m_prev) : 1'b1;
    if (popd) begin
      void'(q_val.pop_front());
      void'(q_ts.pop_front());
    end
    if (qual) begin
      m_rem   = m_rem - 1;
      m_state = (m_rem == 0) ? 2'd3 : 2'd2;
      if (pre == DEPTH && !popd) m_ovf = 1'b1;
      else begin
        q_val.push_back(soi);
        q_ts.push_back(m_ts);
      end
    end
    m_prev = soi;
    @(posedge clk);
    @(negedge clk);
    arm_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] seq [4];
    seq = '{8'h5A, 8'h11, 8'h22, 8'h33};
    step(8'h00, 1'b1, 1'b0, 8'h5A, 3'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(seq[i], 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL reset_fill: got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 31'd0) $display("FAIL reset_low: got %h exp %h", dut_vec(), 31'd0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== 31'd0) $display("FAIL reset_release: got %h exp %h", dut_vec(), 31'd0);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [7:0] drv [5];
    logic [7:0] expv [3];
    drv  = '{8'h00, 8'h5A, 8'h11, 8'h22, 8'h33};
    expv = '{8'h5A, 8'h11, 8'h22};
    step(8'h00, 1'b1, 1'b0, 8'h5A, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(drv[i], 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL mode0_cap: got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if (state_o !== 2'd3 || count_o !== 3'd3) $display("FAIL mode0_done: got state %0d count %0d exp 3 3", state_o, count_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_data_o !== expv[i]) $display("FAIL mode0_data: got %h exp %h", rd_data_o, expv[i]);
      else n_pass++;
      step(8'h33, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL mode0_drain: got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_mode1();
    logic [7:0]  drv [5];
    logic [15:0] t_hit;
    drv = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03};
    step(8'h00, 1'b1, 1'b1, 8'h01, 3'd3, 1'b0);
    t_hit = m_ts;
    for (int i = 0; i < 5; i++) begin
      step(drv[i], 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL mode1_cap: got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if (rd_data_o !== 8'h01 || rd_ts_o !== t_hit) $display("FAIL mode1_head: got %h@%h exp 01@%h", rd_data_o, rd_ts_o, t_hit);
    else n_pass++;
    step(8'h03, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    n_checks++;
    if (rd_data_o !== 8'h02 || rd_ts_o !== t_hit + 16'd2) $display("FAIL mode1_gap: got %h@%h exp 02@%h", rd_data_o, rd_ts_o, t_hit + 16'd2);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(8'h03, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL mode1_drain: got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] drv [6];
    drv = '{8'h33, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    step(8'h00, 1'b1, 1'b0, 8'h33, 3'd6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(drv[i], 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL ovf_cap: got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (overflow_o !== 1'b0 || count_o !== 3'd4) $display("FAIL ovf_early: got ovf %0d count %0d exp 0 4", overflow_o, count_o);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_set: got %0d exp 1", overflow_o);
        else n_pass++;
      end
    end
    n_checks++;
    if (state_o !== 2'd3) $display("FAIL ovf_done: got %0d exp 3", state_o);
    else n_pass++;
    step(8'h00, 1'b1, 1'b1, 8'hEE, 3'd2, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b0 || count_o !== 3'd4 || state_o !== 2'd1) $display("FAIL ovf_rearm: got ovf %0d count %0d state %0d exp 0 4 1", overflow_o, count_o, state_o);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    step(8'hEE, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    n_checks++;
    if (count_o !== 3'd4 || overflow_o !== 1'b0) $display("FAIL full_pop: got count %0d ovf %0d exp 4 0", count_o, overflow_o);
    else n_pass++;
    for (int i = 0; i < 8 && q_val.size() > 0; i++) begin
      if (q_val.size() == 1) begin
        n_checks++;
        if (rd_data_o !== 8'hEE) $display("FAIL full_tail: got %h exp ee", rd_data_o);
        else n_pass++;
      end
      step(8'hEE, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL full_drain: got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 3)), 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL random[%0d]: got %h exp %h", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_len0_wrap();
    logic [15:0] exp_ts [3];
    logic [7:0]  drv [3];
    exp_ts = '{16'hFFFE, 16'hFFFF, 16'h0000};
    drv    = '{8'h77, 8'h78, 8'h79};
    step(8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    n_checks++;
    if (state_o !== 2'd3 || dut_vec() !== model_vec()) $display("FAIL len0: got %h exp %h", dut_vec(), model_vec());
    else n_pass++;
    for (int i = 0; i < 8 && q_val.size() > 0; i++) step(8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    for (int k = 0; k < 70000 && m_ts != 16'hFFFD; k++) @(negedge clk);
    if (m_ts != 16'hFFFD) begin
      n_checks++;
      $display("FAIL wrap_wait: got ts %h exp fffd", m_ts);
    end
    step(8'h00, 1'b1, 1'b0, 8'h77, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(drv[i], 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL wrap_cap: got %h exp %h", dut_vec(), model_vec());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_data_o !== drv[i] || rd_ts_o !== exp_ts[i]) $display("FAIL wrap_ts: got %h@%h exp %h@%h", rd_data_o, rd_ts_o, drv[i], exp_ts[i]);
      else n_pass++;
      step(8'h79, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_mode0();
    test_mode1();
    test_overflow();
    test_full_pop();
    test_random();
    test_len0_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
